// File: rtl/mem_bus_arbiter_pkg.sv
// Shared main-bus package: arbiter state encoding, default sizing and
// the SYSBUS_* request tags used by the requesters on the main bus.
package mem_bus_arbiter_pkg;

  localparam int         NUM_REQ_DEF       = 4;
  localparam int         OWN_W_DEF         = 2;
  localparam logic [3:0] GRANT_TIMEOUT_DEF = 4'd15;

  // Requester tags driven on reqtag by the engines themselves.
  localparam logic [1:0] SYSBUS_TAG_STORE = 2'd0;
  localparam logic [1:0] SYSBUS_TAG_LFILL = 2'd1;
  localparam logic [1:0] SYSBUS_TAG_MISS0 = 2'd2;
  localparam logic [1:0] SYSBUS_TAG_MISS1 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_OWNED   = 2'd2,
    ST_TURN    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Arbitration handshake bundle between the bus requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] grant;
  logic [OWN_W-1:0]   owner;
  logic               bus_idle;
  logic               timeout_err;
  logic               proto_err;

  modport master (
    output req, busy,
    input  grant, owner, bus_idle, timeout_err, proto_err
  );

  modport slave (
    input  req, busy,
    output grant, owner, bus_idle, timeout_err, proto_err
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWN_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [OWN_W-1:0]   o_idx,
  output logic               o_any
);

  // Candidate index at each rotation offset from the pointer.
  logic [OWN_W-1:0] w_cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign w_cand[gi] = OWN_W'((int'(i_ptr) + gi) % NUM_REQ);
  end

  // Scan from the farthest offset back so the nearest hit wins.
  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_idx = w_cand[k];
        o_any = 1'b1;
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Main-bus arbiter: round-robin grant, tenure tracking via busy,
// grant timeout, one-cycle turnaround between tenures.
// Only arbitrates; requesters drive the main bus themselves.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int         NUM_REQ       = NUM_REQ_DEF,
  parameter int         OWN_W         = OWN_W_DEF,
  parameter logic [3:0] GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  arb_state_t         r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [OWN_W-1:0]   r_owner, w_owner_next;
  logic [OWN_W-1:0]   r_ptr, w_ptr_next;
  logic [3:0]         r_cnt, w_cnt_next;
  logic               r_terr, w_terr_next;
  // Cleared by reset so the edge right after reset never grants.
  logic               r_armed;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [OWN_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_own_busy;
  logic               w_own_req;
  logic [OWN_W-1:0]   w_ptr_after;
  logic [3:0]         w_cnt_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_own_busy  = bus.busy[r_owner];
  assign w_own_req   = bus.req[r_owner];
  assign w_ptr_after = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Next-state and next-grant decisions; every exit to TURN advances rr_ptr.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_terr_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && w_pick_any) begin
          w_grant_next = w_pick_oh;
          w_owner_next = w_pick_idx;
          w_cnt_next   = 4'd0;
          w_state_next = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (w_own_busy) begin
          w_state_next = ST_OWNED;
        end else if (!w_own_req) begin
          w_grant_next = '0;
          w_ptr_next   = w_ptr_after;
          w_state_next = ST_TURN;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == GRANT_TIMEOUT) begin
            w_grant_next = '0;
            w_terr_next  = 1'b1;
            w_ptr_next   = w_ptr_after;
            w_state_next = ST_TURN;
          end
        end
      end
      ST_OWNED: begin
        if (!w_own_busy) begin
          w_grant_next = '0;
          w_ptr_next   = w_ptr_after;
          w_state_next = ST_TURN;
        end
      end
      ST_TURN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any tenure immediately without TURN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= 4'd0;
      r_terr  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_terr  <= w_terr_next;
      r_armed <= 1'b1;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;
  assign bus.bus_idle    = (r_grant == '0);
  assign bus.timeout_err = r_terr;
  // Grant is zero outside a tenure, so any busy outside grant is illegal.
  assign bus.proto_err   = ~reset & (|(bus.busy & ~r_grant));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int N = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter_if #(.NUM_REQ(N), .OWN_W(2)) bus_if ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state (tenure-level view of the arbiter)
  int m_hold;     // grantee index, -1 when no grant
  bit m_owned;    // grantee has asserted busy
  bit m_turn;     // turnaround cycle pending
  int m_wait;     // cycles waited for busy
  int m_ptr;
  bit m_tpulse;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.busy = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic model_release();
    m_ptr = (m_hold + 1) % N;
    m_hold = -1;
    m_turn = 1'b1;
  endtask

  task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] bz);
    m_tpulse = 1'b0;
    if (m_turn) begin
      m_turn = 1'b0;
    end else if (m_hold < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_hold < 0 && rq[(m_ptr + k) % N]) begin
          m_hold = (m_ptr + k) % N;
          m_owned = 1'b0;
          m_wait = 0;
        end
      end
    end else if (!m_owned) begin
      if (bz[m_hold]) m_owned = 1'b1;
      else if (!rq[m_hold]) model_release();
      else begin
        m_wait++;
        if (m_wait == TO) begin
          model_release();
          m_tpulse = 1'b1;
        end
      end
    end else if (!bz[m_hold]) begin
      model_release();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.busy = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant got=%b exp=0000", bus_if.grant); end
    n_checks++;
    if (bus_if.bus_idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle got=%b exp=1", bus_if.bus_idle); end
    n_checks++;
    if (bus_if.owner !== 2'd0) begin n_errors++; $display("FAIL reset_owner got=%0d exp=0", bus_if.owner); end
    n_checks++;
    if (bus_if.proto_err !== 1'b0 || bus_if.timeout_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_errs got=%b%b exp=00", bus_if.proto_err, bus_if.timeout_err);
    end
    bus_if.busy = '0;
    reset = 1'b0;
    bus_if.req = 4'b0001;
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_holdoff got=%b exp=0000", bus_if.grant); end
    $display("test_reset done");
  endtask

  task automatic test_single_tenure();
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0001) begin n_errors++; $display("FAIL single_grant got=%b exp=0001", bus_if.grant); end
    bus_if.busy = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (bus_if.grant !== 4'b0001) begin n_errors++; $display("FAIL single_hold[%0d] got=%b exp=0001", i, bus_if.grant); end
    end
    bus_if.busy = '0;
    bus_if.req = '0;
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0000 || bus_if.bus_idle !== 1'b1) begin
      n_errors++; $display("FAIL single_drop got=%b idle=%b exp=0000 idle=1", bus_if.grant, bus_if.bus_idle);
    end
    tick();
    $display("test_single_tenure done");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    bus_if.req = 4'b1111;
    tick();
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % N);
      n_checks++;
      if (bus_if.grant !== exp) begin n_errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", t, bus_if.grant, exp); end
      n_checks++;
      if (bus_if.owner !== 2'(t % N)) begin n_errors++; $display("FAIL rr_owner[%0d] got=%0d exp=%0d", t, bus_if.owner, t % N); end
      bus_if.busy = exp;
      tick();
      tick();
      tick();
      bus_if.busy = '0;
      if (t < 4) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          n_checks++;
          if (bus_if.grant !== 4'b0000 || bus_if.bus_idle !== 1'b1) begin
            n_errors++; $display("FAIL rr_gap[%0d.%0d] got=%b exp=0000", t, g, bus_if.grant);
          end
        end
        tick();
      end
    end
    bus_if.req = '0;
    tick();
    tick();
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_timeout();
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      n_checks++;
      if (bus_if.grant !== 4'b0100 || bus_if.timeout_err !== 1'b0) begin
        n_errors++; $display("FAIL to_hold[%0d] got=%b terr=%b exp=0100 terr=0", i, bus_if.grant, bus_if.timeout_err);
      end
      tick();
    end
    n_checks++;
    if (bus_if.grant !== 4'b0100) begin n_errors++; $display("FAIL to_last got=%b exp=0100", bus_if.grant); end
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0000 || bus_if.timeout_err !== 1'b1) begin
      n_errors++; $display("FAIL to_drop got=%b terr=%b exp=0000 terr=1", bus_if.grant, bus_if.timeout_err);
    end
    bus_if.req = 4'b1111;
    tick();
    n_checks++;
    if (bus_if.timeout_err !== 1'b0) begin n_errors++; $display("FAIL to_pulse_len got=%b exp=0", bus_if.timeout_err); end
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b1000) begin n_errors++; $display("FAIL to_rrptr got=%b exp=1000", bus_if.grant); end
    bus_if.req = '0;
    tick();
    tick();
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_proto_err();
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    bus_if.busy = 4'b0010;
    tick();
    bus_if.busy = 4'b0110;
    #1;
    n_checks++;
    if (bus_if.proto_err !== 1'b1) begin n_errors++; $display("FAIL proto_pulse got=%b exp=1", bus_if.proto_err); end
    tick();
    bus_if.busy = 4'b0010;
    #1;
    n_checks++;
    if (bus_if.proto_err !== 1'b0 || bus_if.grant !== 4'b0010) begin
      n_errors++; $display("FAIL proto_after got=%b grant=%b exp=0 grant=0010", bus_if.proto_err, bus_if.grant);
    end
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0010) begin n_errors++; $display("FAIL proto_grant got=%b exp=0010", bus_if.grant); end
    bus_if.busy = '0;
    bus_if.req = '0;
    tick();
    tick();
    $display("test_proto_err done");
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    bus_if.req = '0;
    tick();
    tick();
    bus_if.req = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b1000) begin n_errors++; $display("FAIL rmid_grant got=%b exp=1000", bus_if.grant); end
    bus_if.busy = 4'b1000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0000 || bus_if.timeout_err !== 1'b0 || bus_if.bus_idle !== 1'b1) begin
      n_errors++; $display("FAIL rmid_drop got=%b terr=%b exp=0000 terr=0", bus_if.grant, bus_if.timeout_err);
    end
    reset = 1'b0;
    bus_if.busy = '0;
    bus_if.req = 4'b1001;
    tick();
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0001) begin n_errors++; $display("FAIL rmid_ptr got=%b exp=0001", bus_if.grant); end
    bus_if.req = '0;
    tick();
    tick();
    tick();
    $display("test_reset_mid_tenure done");
  endtask

  task automatic test_req_drop();
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus_if.grant !== 4'b0100) begin n_errors++; $display("FAIL drop_grant got=%b exp=0100", bus_if.grant); end
    bus_if.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus_if.grant !== 4'b0000 || bus_if.timeout_err !== 1'b0) begin
        n_errors++; $display("FAIL drop_after[%0d] got=%b terr=%b exp=0000 terr=0", i, bus_if.grant, bus_if.timeout_err);
      end
    end
    $display("test_req_drop done");
  endtask

  task automatic test_random();
    logic [N-1:0] rq;
    logic [N-1:0] bz;
    logic [N-1:0] exp_g;
    logic exp_p;
    int busy_pct;
    do_reset();
    m_hold = -1; m_owned = 0; m_turn = 0; m_wait = 0; m_ptr = 0; m_tpulse = 0;
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      busy_pct = (c / 500) % 3 == 0 ? 0 : ((c / 500) % 3 == 1 ? 60 : 90);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      bz = '0;
      if (m_hold >= 0 && $urandom_range(0, 99) < busy_pct) bz[m_hold] = 1'b1;
      if ($urandom_range(0, 19) == 0) bz[$urandom_range(0, N - 1)] = 1'b1;
      bus_if.req = rq;
      bus_if.busy = bz;
      #1;
      exp_p = 1'b0;
      for (int b = 0; b < N; b++) if (bz[b] && b != m_hold) exp_p = 1'b1;
      n_checks++;
      if (bus_if.proto_err !== exp_p) begin n_errors++; $display("FAIL rnd_proto[%0d] got=%b exp=%b", c, bus_if.proto_err, exp_p); end
      @(posedge clk);
      model_step(rq, bz);
      #1;
      exp_g = (m_hold >= 0) ? (4'b0001 << m_hold) : 4'b0000;
      n_checks++;
      if (bus_if.grant !== exp_g || bus_if.bus_idle !== (m_hold < 0) || bus_if.timeout_err !== m_tpulse) begin
        n_errors++;
        $display("FAIL rnd_out[%0d] got=%b idle=%b terr=%b exp=%b idle=%b terr=%b", c,
                 bus_if.grant, bus_if.bus_idle, bus_if.timeout_err, exp_g, (m_hold < 0), m_tpulse);
      end
      if (m_hold >= 0) begin
        n_checks++;
        if (bus_if.owner !== 2'(m_hold)) begin n_errors++; $display("FAIL rnd_owner[%0d] got=%0d exp=%0d", c, bus_if.owner, m_hold); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req = '0;
    bus_if.busy = '0;
    test_reset();
    test_single_tenure();
    test_round_robin();
    test_timeout();
    test_proto_err();
    test_reset_mid_tenure();
    test_req_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
